ahb_out_fifo: RTL

AHB_OUT_FIFO -- requirements
Module: ahb_out_fifo

---
 rtl/ahb_out_pkg.sv | 30 +++
 rtl/ahb_out_fifo_sync_fifo.sv | 72 +++++++
 rtl/ahb_out_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ahb_out_pkg.sv
// rtl/ahb_out_pkg.sv - register map and bit positions shared by the AHB output FIFO
//
// Purpose: register offsets (HADDR[3:2]), STATUS/CTRL bit positions and the
// decoded offset type used by ahb_out_fifo.
// Ports: none (package).

package ahb_out_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  typedef enum logic [1:0] {
    REG_DATA   = OFF_DATA,
    REG_STATUS = OFF_STATUS,
    REG_CTRL   = OFF_CTRL,
    REG_RSVD   = OFF_RSVD
  } reg_offset_t;

endpackage

// File: rtl/ahb_out_fifo_sync_fifo.sv
// rtl/ahb_out_fifo_sync_fifo.sv - synchronous FIFO storage, pointers and occupancy count
//
// Purpose: DEPTH-entry single-clock FIFO with flush. Push and pop may complete
// in the same cycle even when full; flush dominates both.
// Ports:
//   clk, resetn        - clock, synchronous active-low reset
//   push, push_data    - write request and word
//   pop                - read request (ignored when empty)
//   flush              - clears pointers and count on the next edge
//   head               - word at the read pointer (unqualified)
//   full, empty, count - occupancy, count in 0..DEPTH

module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DATA_WIDTH-1:0]      head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = DEPTH;
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           cnt;
  logic                  pop_ok;
  logic                  push_ok;

  assign full  = (cnt == FULL_COUNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it is paired with a pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ahb_out_fifo.sv
// rtl/ahb_out_fifo.sv - AHB-Lite slave that feeds a word FIFO to a valid/ready consumer
//
// Purpose: AHB register front end (DATA push, STATUS, CTRL), consumer handshake
// and level interrupt around a sync_fifo.
// Ports:
//   HCLK, HRESETn                   - clock, synchronous active-low reset
//   HSEL..HREADY, HRDATA, HREADYOUT - AHB-Lite slave (zero wait states)
//   DataOut, DataValid, DataReady   - FIFO head to the consumer
//   Irq                             - irq_en & (empty | overflow)

module ahb_out_fifo
  import ahb_out_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  input  logic                  DataReady,
  output logic                  Irq
);

  localparam int AW = $clog2(DEPTH);

  // Captured address phase.
  logic        dp_valid;
  logic        dp_write;
  reg_offset_t dp_off;

  logic        enable;
  logic        irq_en;
  logic        overflow;

  logic                  wr_en;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  ovf_clear;
  logic                  ovf_set;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AW:0]           fifo_count;

  logic [7:0]            count8;
  logic [31:0]           head32;
  logic [31:0]           status_word;
  logic [31:0]           ctrl_word;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};

  assign HREADYOUT = 1'b1;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= REG_DATA;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_off   <= reg_offset_t'(HADDR[3:2]);
    end
  end

  assign wr_en     = dp_valid & dp_write & HREADY;
  assign push      = wr_en & (dp_off == REG_DATA);
  assign flush     = wr_en & (dp_off == REG_CTRL) & HWDATA[CTRL_FLUSH_BIT];
  assign ovf_clear = wr_en & (dp_off == REG_STATUS) & HWDATA[STATUS_OVF_BIT];

  // Outputs are forced quiet while reset is held so the consumer never sees a
  // word from a FIFO that is about to be cleared.
  assign DataValid = HRESETn & enable & ~fifo_empty;
  assign DataOut   = (HRESETn && !fifo_empty) ? fifo_head : '0;
  assign pop       = DataValid & DataReady;
  assign Irq       = HRESETn & irq_en & (fifo_empty | overflow);

  // A dropped push is only an overflow when neither a pop nor a flush
  // would have made room for it.
  assign ovf_set = push & fifo_full & ~pop & ~flush;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && dp_off == REG_CTRL) begin
        enable <= HWDATA[CTRL_ENABLE_BIT];
        irq_en <= HWDATA[CTRL_IRQ_EN_BIT];
      end
      if (ovf_clear)    overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .resetn    (HRESETn),
    .push      (push),
    .push_data (HWDATA[DATA_WIDTH-1:0]),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    count8           = '0;
    count8[AW:0]     = fifo_count;
    head32           = '0;
    head32[DATA_WIDTH-1:0] = DataOut;

    status_word                              = '0;
    status_word[STATUS_EMPTY_BIT]            = fifo_empty;
    status_word[STATUS_FULL_BIT]             = fifo_full;
    status_word[STATUS_OVF_BIT]              = overflow;
    status_word[STATUS_COUNT_LSB +: 8]       = count8;

    // Flush is a strobe, so it always reads back as 0.
    ctrl_word                  = '0;
    ctrl_word[CTRL_ENABLE_BIT] = enable;
    ctrl_word[CTRL_IRQ_EN_BIT] = irq_en;

    HRDATA = '0;
    if (HRESETn && dp_valid && !dp_write) begin
      case (dp_off)
        REG_DATA:   HRDATA = head32;
        REG_STATUS: HRDATA = status_word;
        REG_CTRL:   HRDATA = ctrl_word;
        default:    HRDATA = '0;
      endcase
    end
  end

endmodule
